wb_lfsr_seq_master: RTL and testbench

Wishbone bus initiator that drives the byte-addressed LFSR peripheral from the other end of its bus. A single `i_start` pulse makes it:
- program a 32-bit seed,
- pulse the peripheral's reset/load controls,
- read back a requested number of serial LFSR bits, assembled into a parallel word.

It sits between on-chip control logic (or a test harness) and the LFSR peripheral's Wishbone slave port.

---
 rtl/wb_lfsr_seq_master.sv | 102 ++++++++++
 tb/tb_wb_lfsr_seq_master.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_lfsr_seq_master.sv
// wb_lfsr_seq_master: Wishbone initiator that seeds the LFSR peripheral and reads back N serial bits.
// Optional macro WB_SEQ_TIMEOUT_EN adds a per-transaction ack watchdog that aborts with o_err.
module wb_lfsr_seq_master #(
   parameter int OUT_W   = 32,
   parameter int TIMEOUT = 15
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [31:0]      i_seed,
   input  logic [5:0]       i_count,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_err,
   output logic [OUT_W-1:0] o_result,
   output logic             o_wb_cyc,
   output logic             o_wb_stb,
   output logic             o_wb_we,
   output logic [2:0]       o_wb_addr,
   output logic [7:0]       o_wb_data,
   input  logic             i_wb_stall,
   input  logic             i_wb_ack,
   input  logic             i_wb_data
);
   localparam int RW = $clog2(OUT_W + 1);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
   state_t state, state_d;
   logic [2:0] txn, nt;
   logic [RW-1:0] rcnt, n_q;
   logic [31:0] seed_q;
   logic go, acked, last, to;
   assign go = state == IDLE && i_start;
   assign acked = state == WAIT && i_wb_ack;
   // txn 0..5 are the fixed writes; txn 6 repeats for every read
   assign last = (txn == 3'd5 && n_q == '0) || (txn == 3'd6 && rcnt == n_q - RW'(1));
   assign nt = txn == 3'd6 ? 3'd6 : txn + 3'd1;
   assign o_wb_cyc = state == REQ || state == WAIT;
   assign o_wb_stb = state == REQ;
   assign o_busy = state != IDLE;
   assign o_done = state == DONE;
`ifdef WB_SEQ_TIMEOUT_EN
   logic [7:0] wd;
   logic err_q;
   assign to = o_wb_cyc && wd == 8'(TIMEOUT - 1);
   always_ff @(posedge i_clk)
      if (i_reset) begin
         wd <= '0;
         err_q <= 1'b0;
      end else begin
         wd <= o_wb_cyc && !acked ? wd + 8'd1 : 8'd0;
         err_q <= go ? 1'b0 : err_q | (to & !acked);
      end
   assign o_err = o_done && err_q;
`else
   assign to = 1'b0;
   assign o_err = 1'b0;
`endif
   always_ff @(posedge i_clk)
      if (i_reset) state <= IDLE;
      else state <= state_d;
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    state_d = i_start ? REQ : IDLE;
         REQ:     state_d = to ? DONE : i_wb_stall ? REQ : WAIT;
         WAIT:    state_d = i_wb_ack ? (last ? DONE : REQ) : to ? DONE : WAIT;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge i_clk)
      if (i_reset) begin
         txn <= '0;
         rcnt <= '0;
         n_q <= '0;
         seed_q <= '0;
         o_wb_we <= 1'b0;
         o_wb_addr <= '0;
         o_wb_data <= '0;
         o_result <= '0;
      end else if (go) begin
         txn <= '0;
         rcnt <= '0;
         seed_q <= i_seed;
         n_q <= 32'(i_count) > OUT_W ? RW'(OUT_W) : RW'(i_count);
         o_wb_we <= 1'b1;
         o_wb_addr <= 3'd0;
         o_wb_data <= i_seed[7:0];
         o_result <= '0;
      end else if (acked) begin
         if (txn == 3'd6) begin
            o_result <= {o_result[OUT_W-2:0], i_wb_data};
            rcnt <= rcnt + RW'(1);
         end
         if (!last) begin
            txn <= nt;
            o_wb_we <= nt != 3'd6;
            o_wb_addr <= nt[2] ? (nt == 3'd6 ? 3'd0 : 3'd4) : nt;
            o_wb_data <= nt[2] ? (nt == 3'd4 ? 8'h03 : 8'h00) : 8'(seed_q >> {nt[1:0], 3'b000});
         end
      end
endmodule

// File: tb/tb_wb_lfsr_seq_master.sv
// tb_wb_lfsr_seq_master: randomized and directed bench with a Wishbone slave model and spec-level reference.
// Timeout scenario runs only when WB_SEQ_TIMEOUT_EN is defined.
module tb_wb_lfsr_seq_master;
   localparam int OUT_W = 32;
   localparam int TIMEOUT = 15;
   logic clk = 1'b0;
   logic reset, start, stall, ack, rdat;
   logic [31:0] seed;
   logic [5:0] count;
   logic busy, done, err, cyc, stb, we;
   logic [2:0] addr;
   logic [7:0] wdat;
   logic [OUT_W-1:0] result;
   int n_chk = 0;
   int n_fail = 0;
   int stall_tab[64];
   int dly_tab[64];
   bit bits_tab[64];
   logic sl_clr;
   int pend, tidx, nrd, stall_left, unstable, gap, n_done;
   bit fresh, pbit;
   logic h_we;
   logic [2:0] h_addr;
   logic [7:0] h_data;
   logic log_we[$];
   logic [2:0] log_addr[$];
   logic [7:0] log_data[$];
   int lat, nd;
   logic [7:0] pat;

   wb_lfsr_seq_master #(.OUT_W(OUT_W), .TIMEOUT(TIMEOUT)) dut (
      .i_clk(clk), .i_reset(reset), .i_start(start), .i_seed(seed), .i_count(count),
      .o_busy(busy), .o_done(done), .o_err(err), .o_result(result),
      .o_wb_cyc(cyc), .o_wb_stb(stb), .o_wb_we(we), .o_wb_addr(addr), .o_wb_data(wdat),
      .i_wb_stall(stall), .i_wb_ack(ack), .i_wb_data(rdat)
   );

   always #5 clk = ~clk;

   // slave model: per-transaction stall and ack delay, logs every accepted request
   always begin
      @(posedge clk);
      #1;
      if (done) n_done++;
      if (busy && !done && !cyc) gap++;
      if (sl_clr) begin
         pend = -1; tidx = 0; nrd = 0; stall_left = stall_tab[0]; unstable = 0; gap = 0;
         fresh = 1; ack = 0; rdat = 0; stall = 0;
         log_we.delete(); log_addr.delete(); log_data.delete();
      end else begin
         if (cyc && stb && fresh) begin
            h_we = we; h_addr = addr; h_data = wdat; fresh = 0;
         end else if (cyc && {we, addr, wdat} !== {h_we, h_addr, h_data}) unstable++;
         ack = 0; rdat = 0;
         if (pend > 0) pend--;
         else if (pend == 0) begin
            ack = 1; rdat = pbit; pend = -1; fresh = 1;
         end
         stall = 0;
         if (cyc && stb) begin
            if (stall_left > 0) begin
               stall = 1; stall_left--;
            end else begin
               log_we.push_back(we); log_addr.push_back(addr); log_data.push_back(wdat);
               pbit = we ? 1'b0 : bits_tab[nrd];
               if (!we) nrd++;
               pend = dly_tab[tidx];
               tidx++;
               stall_left = stall_tab[tidx];
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_tabs;
      for (int i = 0; i < 64; i++) begin
         stall_tab[i] = 0; dly_tab[i] = 0; bits_tab[i] = 0;
      end
   endtask

   task automatic run_seq(input logic [31:0] s, input int cnt, input string tag, output int l);
      int n, exp_lat, bad, ndn;
      logic [63:0] exp_res;
      logic [2:0] ea[6];
      logic [7:0] ed[6];
      n = cnt > OUT_W ? OUT_W : cnt;
      exp_lat = 2 * (6 + n);
      for (int i = 0; i < 6 + n; i++) exp_lat += stall_tab[i] + dly_tab[i];
      exp_res = 0;
      for (int i = 0; i < n; i++) exp_res += 64'(bits_tab[i]) << (n - 1 - i);
      ea = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
      ed = '{s[7:0], s[15:8], s[23:16], s[31:24], 8'h03, 8'h00};
      sl_clr = 1;
      tick;
      sl_clr = 0;
      seed = s; count = 6'(cnt); start = 1; ndn = n_done;
      tick;
      start = 0; seed = $urandom; count = 6'($urandom);
      l = 0;
      for (int k = 1; k <= 3000; k++) begin
         start = k == 3;
         tick;
         if (done) begin
            l = k;
            break;
         end
      end
      start = 0;
      check({tag, "_done_latency"}, l, exp_lat);
      check({tag, "_result"}, result, exp_res);
      check({tag, "_err"}, err, 0);
      check({tag, "_cyc_at_done"}, cyc, 0);
      check({tag, "_busy_at_done"}, busy, 1);
      check({tag, "_txn_count"}, log_we.size(), 6 + n);
      for (int i = 0; i < 6 && i < log_we.size(); i++) begin
         check($sformatf("%s_wr%0d", tag, i), {log_we[i], log_addr[i], log_data[i]}, {1'b1, ea[i], ed[i]});
      end
      bad = 0;
      for (int i = 6; i < log_we.size(); i++)
         if ({log_we[i], log_addr[i], log_data[i]} !== 12'h0) bad++;
      check({tag, "_bad_reads"}, bad, 0);
      check({tag, "_unstable"}, unstable, 0);
      check({tag, "_cyc_gap"}, gap, 0);
      tick;
      check({tag, "_busy_fall"}, busy, 0);
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_result_held"}, result, exp_res);
      check({tag, "_done_count"}, n_done, ndn + 1);
   endtask

   initial begin
      reset = 1; start = 0; seed = 0; count = 0; sl_clr = 1; n_done = 0;
      clr_tabs();
      tick;
      tick;
      check("rst_bus", {cyc, stb, we, addr, wdat}, 0);
      check("rst_status", {busy, done, err}, 0);
      check("rst_result", result, 0);
      reset = 0;
      sl_clr = 0;
      tick;
      check("idle_busy", busy, 0);

      run_seq(32'hDEADBEEF, 0, "n0", lat);
      check("n0_lat12", lat, 12);

      pat = 8'b1011_0010;
      for (int i = 0; i < 8; i++) bits_tab[i] = pat[7 - i];
      run_seq(32'h1234_5678, 8, "n8", lat);
      check("n8_lat28", lat, 28);
      check("n8_b2", result[7:0], 8'hB2);

      clr_tabs();
      stall_tab[1] = 3;
      run_seq(32'hDEADBEEF, 0, "stall", lat);
      check("stall_lat15", lat, 15);

      clr_tabs();
      for (int i = 0; i < 64; i++) bits_tab[i] = 1'($urandom);
      run_seq($urandom, 40, "clamp", lat);
      check("clamp_lat76", lat, 76);

      clr_tabs();
      for (int i = 0; i < 64; i++) bits_tab[i] = 1'($urandom);
      dly_tab[8] = 3;
      sl_clr = 1;
      tick;
      sl_clr = 0;
      seed = $urandom; count = 6'd8; start = 1;
      tick;
      start = 0;
      for (int k = 0; k < 200 && nrd < 3; k++) tick;
      check("rst_reach_read3", nrd, 3);
      reset = 1;
      tick;
      reset = 0;
      check("midrst_bus", {cyc, stb, we, addr, wdat}, 0);
      check("midrst_status", {busy, done, err}, 0);
      check("midrst_result", result, 0);
      nd = n_done;
      repeat (8) tick;
      check("late_ack_busy", busy, 0);
      check("late_ack_no_done", n_done, nd);
      check("late_ack_result", result, 0);
      run_seq($urandom, 5, "after_rst", lat);

      for (int r = 0; r < 5; r++) begin
         clr_tabs();
         for (int i = 0; i < 64; i++) begin
            stall_tab[i] = $urandom_range(0, 2);
            dly_tab[i] = $urandom_range(0, 2);
            bits_tab[i] = 1'($urandom);
         end
         run_seq($urandom, $urandom_range(0, 63), $sformatf("rnd%0d", r), lat);
      end

`ifdef WB_SEQ_TIMEOUT_EN
      clr_tabs();
      dly_tab[0] = 1000;
      sl_clr = 1;
      tick;
      sl_clr = 0;
      seed = $urandom; count = 6'd4; start = 1;
      tick;
      start = 0;
      lat = 0;
      for (int k = 1; k <= 100; k++) begin
         tick;
         if (done) begin
            lat = k;
            break;
         end
      end
      check("to_latency", lat, TIMEOUT);
      check("to_err", err, 1);
      check("to_cyc", {cyc, stb}, 0);
      tick;
      check("to_err_pulse", {err, busy}, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end
endmodule
